// File: rtl/blk_mem_pkg.sv
// Shared definitions for the block-memory arbiter: FSM states, grant ids and
// the block offset width.
package blk_mem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // 32-byte blocks: the low address bits never reach the memory.
  localparam int BLK_OFFSET_BITS = 5;

endpackage

// File: rtl/blk_mem_arbiter.sv
// Shares one block-memory port between I-cache refills and D-cache refill /
// writeback, one transaction at a time, round-robin between the two caches.
module blk_mem_arbiter
  import blk_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [BLK_W-1:0]  i_rdata,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic              d_done,
  output logic [BLK_W-1:0]  d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_blk_read,
  output logic              mem_blk_write,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_read_valid,
  input  logic              mem_write_valid,
  output logic              busy,
  output logic              timeout_err,
  output state_t            dbg_state
);

  // Handshake: requests are levels held until the matching one-cycle done
  // pulse; a request still high once the FSM is back in IDLE is a new request.
  // Memory side: a strobe stays high with stable address/data until the
  // matching valid flag is seen; a valid of the other type is ignored.

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ERR   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << BLK_OFFSET_BITS;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             last_grant_nxt;
  logic             gnt;
  logic             gnt_id;
  logic             d_any;
  logic             mem_phase;
  logic             mem_ok;
  logic             err_q;
  logic [CNT_W-1:0] wait_cnt;

  assign d_any     = d_rd_req | d_wr_req;
  assign mem_phase = (state == I_RD) || (state == D_RD) || (state == D_WR);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // wait_cnt holds the number of finished wait cycles, so the error is already
  // visible in the TIMEOUT-th wait cycle; err_q keeps it afterwards.
  assign timeout_err = err_q | (mem_phase && (wait_cnt >= CNT_ERR));

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt            = 1'b0;
    gnt_id         = GNT_I;
    mem_ok         = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_any) begin
          gnt = 1'b1;
          if (i_req && d_any) gnt_id = ~last_grant;
          else if (i_req)     gnt_id = GNT_I;
          else                gnt_id = GNT_D;
          last_grant_nxt = gnt_id;
          if (gnt_id == GNT_I) state_nxt = I_RD;
          else                 state_nxt = d_wr_req ? D_WR : D_RD;
        end
      end
      I_RD, D_RD: mem_ok = mem_read_valid;
      D_WR:       mem_ok = mem_write_valid;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (mem_ok) state_nxt = DONE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      last_grant    <= GNT_D;
      wait_cnt      <= '0;
      err_q         <= 1'b0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      mem_addr      <= '0;
      mem_blk_read  <= 1'b0;
      mem_blk_write <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      if (gnt) begin
        wait_cnt <= '0;
        if (gnt_id == GNT_I) begin
          mem_addr     <= i_addr & ADDR_MASK;
          mem_blk_read <= 1'b1;
        end else begin
          // A writeback wins over a refill from the same cache.
          mem_addr      <= d_addr & ADDR_MASK;
          mem_blk_read  <= ~d_wr_req;
          mem_blk_write <= d_wr_req;
          if (d_wr_req) mem_wdata <= d_wdata;
        end
      end else if (mem_phase) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= CNT_ERR) err_q <= 1'b1;
        if (mem_ok) begin
          mem_blk_read  <= 1'b0;
          mem_blk_write <= 1'b0;
          if (state == I_RD) begin
            i_rdata <= mem_rdata;
            i_done  <= 1'b1;
          end else begin
            if (state == D_RD) d_rdata <= mem_rdata;
            d_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Directed bench for blk_mem_arbiter: a memory model answers strobes after a
// programmable latency; a monitor pops expected completions from exp_q.
`timescale 1ns/1ps
module tb_blk_mem_arbiter;
  import blk_mem_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int BLK_W   = 256;
  localparam int TIMEOUT = 4;
  localparam int EXP_W   = 2 + ADDR_W + BLK_W;
  localparam logic [1:0] K_I   = 2'd0;
  localparam logic [1:0] K_DRD = 2'd1;
  localparam logic [1:0] K_DWR = 2'd2;

  logic              CLK;
  logic              RESET;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [BLK_W-1:0]  i_rdata;
  logic              d_rd_req;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_addr;
  logic [BLK_W-1:0]  d_wdata;
  logic              d_done;
  logic [BLK_W-1:0]  d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_blk_read;
  logic              mem_blk_write;
  logic [BLK_W-1:0]  mem_wdata;
  logic [BLK_W-1:0]  mem_rdata;
  logic              mem_read_valid;
  logic              mem_write_valid;
  logic              busy;
  logic              timeout_err;
  state_t            dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int mem_lat = 1;
  bit wrong_pulse = 1'b0;
  int last_len = 0;

  blk_mem_arbiter #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_blk_read(mem_blk_read), .mem_blk_write(mem_blk_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_valid(mem_read_valid), .mem_write_valid(mem_write_valid),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required the bench to finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [BLK_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
    return r;
  endfunction

  function automatic logic [EXP_W-1:0] mk(input logic [1:0] k, input logic [ADDR_W-1:0] a,
                                          input logic [BLK_W-1:0] d);
    return {k, a, d};
  endfunction

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic apply_reset();
    RESET = 1'b1; i_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_done(input bit want_i, input bit want_d, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge CLK);
      seen = (want_i && i_done) || (want_d && d_done);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no done pulse in 200 cycles, required one", name);
    end
  endtask

  task automatic wait_strobe(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge CLK);
      seen = mem_blk_read || mem_blk_write;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no memory strobe in 50 cycles, required one", name);
    end
  endtask

  // Memory model: answers the strobe in its mem_lat-th cycle.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    mem_read_valid = 1'b0; mem_write_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge CLK);
      mem_read_valid = 1'b0; mem_write_valid = 1'b0;
      if (mem_blk_read || mem_blk_write) begin
        cnt++;
        if (cnt == mem_lat) begin
          if (mem_blk_read) begin
            mem_read_valid = 1'b1;
            mem_rdata = pat(mem_addr);
          end else begin
            mem_write_valid = 1'b1;
          end
        end else if (wrong_pulse && cnt == 1) begin
          if (mem_blk_read) mem_write_valid = 1'b1;
          else              mem_read_valid  = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    bit in_strobe, s_wr, l_wr, prev_i, prev_d;
    int s_len;
    logic [ADDR_W-1:0] s_addr, l_addr;
    logic [BLK_W-1:0] s_wdata, l_wdata, data;
    logic [EXP_W-1:0] e;
    logic [1:0] kind;
    in_strobe = 0; s_wr = 0; l_wr = 0; prev_i = 0; prev_d = 0; s_len = 0;
    s_addr = '0; l_addr = '0; s_wdata = '0; l_wdata = '0;
    forever begin
      @(negedge CLK);
      if (mem_blk_read || mem_blk_write) begin
        if (!in_strobe) begin
          in_strobe = 1; s_len = 1; s_addr = mem_addr; s_wr = mem_blk_write; s_wdata = mem_wdata;
          chk("addr_align", BLK_W'(mem_addr[4:0]), '0);
        end else begin
          s_len++;
          chk("addr_stable", BLK_W'(mem_addr), BLK_W'(s_addr));
          if (s_wr) chk("wdata_stable", mem_wdata, s_wdata);
        end
        chk("strobe_type", BLK_W'({mem_blk_read, mem_blk_write}), BLK_W'({~s_wr, s_wr}));
      end else if (in_strobe) begin
        in_strobe = 0; last_len = s_len; l_wr = s_wr; l_addr = s_addr; l_wdata = s_wdata;
      end
      if (i_done || d_done) begin
        chk("done_excl", BLK_W'(i_done & d_done), '0);
        chk("done_pulse", BLK_W'((i_done && prev_i) || (d_done && prev_d)), '0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: i_done=%0b d_done=%0b, required no done", i_done, d_done);
        end else begin
          e = exp_q.pop_front();
          kind = i_done ? K_I : (l_wr ? K_DWR : K_DRD);
          chk("done_kind", BLK_W'(kind), BLK_W'(e[EXP_W-1 -: 2]));
          chk("done_addr", BLK_W'(l_addr), BLK_W'(e[BLK_W +: ADDR_W]));
          data = i_done ? i_rdata : (l_wr ? l_wdata : d_rdata);
          chk("done_data", data, e[BLK_W-1:0]);
        end
      end
      prev_i = i_done; prev_d = d_done;
    end
  end

  // Directed stimulus
  initial begin : stim
    logic [BLK_W-1:0] wd;
    int dones;
    RESET = 1'b1; i_req = 0; i_addr = '0; d_rd_req = 0; d_wr_req = 0; d_addr = '0; d_wdata = '0;
    apply_reset();
    chk("rst_busy", BLK_W'(busy), '0);
    chk("rst_i_done", BLK_W'(i_done), '0);
    chk("rst_d_done", BLK_W'(d_done), '0);
    chk("rst_rd", BLK_W'(mem_blk_read), '0);
    chk("rst_wr", BLK_W'(mem_blk_write), '0);
    chk("rst_addr", BLK_W'(mem_addr), '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    chk("rst_err", BLK_W'(timeout_err), '0);
    chk("rst_state", BLK_W'(dbg_state), BLK_W'(IDLE));

    // I-cache read, valid in the 2nd strobe cycle
    mem_lat = 2;
    i_addr = 32'h0040_0020;
    exp_q.push_back(mk(K_I, 32'h0040_0020, pat(32'h0040_0020)));
    i_req = 1'b1;
    wait_done(1, 0, "t1_done");
    i_req = 1'b0;
    @(negedge CLK);
    chk("t1_strobe_len", BLK_W'(last_len), BLK_W'(2));
    chk("t1_idle", BLK_W'(busy), '0);

    // Writeback and refill together: write first, masked address
    wd = pat(32'hCAFE_F00D);
    d_addr = 32'h1000_0047; d_wdata = wd;
    exp_q.push_back(mk(K_DWR, 32'h1000_0040, wd));
    exp_q.push_back(mk(K_DRD, 32'h1000_0040, pat(32'h1000_0040)));
    d_rd_req = 1'b1; d_wr_req = 1'b1;
    wait_done(0, 1, "t2_wr_done");
    d_wr_req = 1'b0;
    wait_done(0, 1, "t2_rd_done");
    d_rd_req = 1'b0;
    @(negedge CLK);
    chk("t2_strobe_len", BLK_W'(last_len), BLK_W'(2));

    // Wrong-type valid during D_RD is ignored
    mem_lat = 3; wrong_pulse = 1'b1;
    d_addr = 32'h0000_3000;
    exp_q.push_back(mk(K_DRD, 32'h0000_3000, pat(32'h0000_3000)));
    d_rd_req = 1'b1;
    wait_done(0, 1, "t4_done");
    d_rd_req = 1'b0; wrong_pulse = 1'b0;
    @(negedge CLK);
    chk("t4_strobe_len", BLK_W'(last_len), BLK_W'(3));
    chk("t4_no_early_err", BLK_W'(timeout_err), '0);

    // Both caches held from reset: I, D, I, D
    apply_reset();
    mem_lat = 1;
    i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    exp_q.push_back(mk(K_I,   32'h0000_1000, pat(32'h0000_1000)));
    exp_q.push_back(mk(K_DRD, 32'h0000_2000, pat(32'h0000_2000)));
    exp_q.push_back(mk(K_I,   32'h0000_1000, pat(32'h0000_1000)));
    exp_q.push_back(mk(K_DRD, 32'h0000_2000, pat(32'h0000_2000)));
    i_req = 1'b1; d_rd_req = 1'b1;
    repeat (4) wait_done(1, 1, "t3_done");
    i_req = 1'b0; d_rd_req = 1'b0;
    repeat (2) @(negedge CLK);

    // Timeout: error from the 4th wait cycle, sticky past completion
    mem_lat = 12;
    i_addr = 32'h0000_5000;
    exp_q.push_back(mk(K_I, 32'h0000_5000, pat(32'h0000_5000)));
    i_req = 1'b1;
    wait_strobe("t5_strobe");
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge CLK);
      chk($sformatf("t5_err_cycle%0d", k), BLK_W'(timeout_err), BLK_W'(k >= 4));
    end
    wait_done(1, 0, "t5_done");
    i_req = 1'b0;
    @(negedge CLK);
    chk("t5_err_sticky", BLK_W'(timeout_err), BLK_W'(1));
    chk("t5_strobe_len", BLK_W'(last_len), BLK_W'(12));

    // Reset in the middle of I_RD
    mem_lat = 1000;
    i_addr = 32'h0000_6000;
    i_req = 1'b1;
    wait_strobe("t6_strobe");
    repeat (5) @(negedge CLK);
    chk("t6_err_before", BLK_W'(timeout_err), BLK_W'(1));
    RESET = 1'b1; i_req = 1'b0;
    @(negedge CLK);
    chk("t6_busy", BLK_W'(busy), '0);
    chk("t6_rd", BLK_W'(mem_blk_read), '0);
    chk("t6_err", BLK_W'(timeout_err), '0);
    chk("t6_state", BLK_W'(dbg_state), BLK_W'(IDLE));
    RESET = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge CLK);
      if (i_done) dones++;
    end
    chk("t6_no_done", BLK_W'(dones), '0);

    chk("exp_q_empty", BLK_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
